// File: rtl/instruction_phase_sequencer.sv
// Instruction phase sequencer: the stage upstream of the register sequencer.
// It steps through the FETCH -> DECODE -> EXECUTE -> COMMIT phases and drives
// a one-hot strobe for the current phase. It also latches the fetched
// instruction word, and it can park in HALT at an instruction boundary.
//
// A FETCH phase lasts until MEM_RDY is seen. A counter bounds that wait. On
// timeout the sequencer latches NOP_OPCODE, pulses BUS_ERR for one cycle and
// moves on to DECODE. An EXECUTE phase lasts for as long as EXEC_WAIT is high.
//
// Ports:
//   CLK          system clock; all state changes on the rising edge
//   RESET        synchronous active-high reset
//   DIN          instruction word from the memory data bus
//   MEM_RDY      memory data valid on DIN this cycle
//   PC_ENX       advance-PC control for the current instruction
//   EXEC_WAIT    hold in EXECUTE (sampled only in EXECUTE)
//   HALT_REQ     halt request (sampled only in COMMIT and HALT)
//   FETCH/DECODE/EXECUTE/COMMIT  one-hot phase strobes
//   MEM_RD       memory read request (same as FETCH)
//   INSTRUCTION  latched instruction word
//   PC_INC       PC increment pulse (COMMIT && PC_ENX)
//   HALTED       parked at an instruction boundary
//   BUS_ERR      one-cycle pulse after a fetch timeout
module instruction_phase_sequencer #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [DATA_WIDTH-1:0] NOP_OPCODE = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  MEM_RDY,
  input  logic                  PC_ENX,
  input  logic                  EXEC_WAIT,
  input  logic                  HALT_REQ,
  output logic                  FETCH,
  output logic                  DECODE,
  output logic                  EXECUTE,
  output logic                  COMMIT,
  output logic                  MEM_RD,
  output logic [DATA_WIDTH-1:0] INSTRUCTION,
  output logic                  PC_INC,
  output logic                  HALTED,
  output logic                  BUS_ERR
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Count value on the last permitted waiting FETCH cycle.
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StCommit,
    StHalt
  } state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic [CntW-1:0]         cnt_q;
  logic                    bus_err_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (MEM_RDY) begin
            // A ready handshake on the timeout edge still wins.
            instr_q <= DIN;
            cnt_q   <= '0;
            state_q <= StDecode;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
            instr_q   <= NOP_OPCODE;
            bus_err_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StDecode;
          end else if (cnt_q != CntMax) begin
            // Saturate rather than wrap (only reachable with the timeout disabled).
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDecode: state_q <= StExecute;
        StExecute: begin
          if (!EXEC_WAIT) state_q <= StCommit;
        end
        StCommit: state_q <= HALT_REQ ? StHalt : StFetch;
        StHalt: begin
          if (!HALT_REQ) state_q <= StFetch;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    FETCH   = (state_q == StFetch);
    DECODE  = (state_q == StDecode);
    EXECUTE = (state_q == StExecute);
    COMMIT  = (state_q == StCommit);
    HALTED  = (state_q == StHalt);
    MEM_RD  = FETCH;
    PC_INC  = COMMIT & PC_ENX;
  end

  assign INSTRUCTION = instr_q;
  assign BUS_ERR     = bus_err_q;

endmodule

// File: doc/instruction_phase_sequencer.md
Name: instruction_phase_sequencer

Overview:
- Upstream stage of the register sequencer. Generates the one-hot FETCH/DECODE/EXECUTE/COMMIT phase strobes and latches the fetched instruction word.
- Fetch phase stretches until the memory handshake completes. Execute phase stretches on a wait request.
- Supports halt at the instruction boundary.
- Bounds the fetch wait with a timeout counter that substitutes a NOP opcode and flags a bus error.

Parameters:
- DATA_WIDTH, 16, width of DIN and INSTRUCTION.
- TIMEOUT_CYCLES, 15, maximum FETCH cycles spent waiting for MEM_RDY; 0 disables the timeout.
- NOP_OPCODE, 16'h0000, word latched into INSTRUCTION when a fetch times out.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- DIN  input  DATA_WIDTH  instruction word from the memory data bus.
- MEM_RDY  input  1  memory has valid data on DIN this cycle.
- PC_ENX  input  1  decoded "advance PC" control for the current instruction.
- EXEC_WAIT  input  1  hold in EXECUTE; sampled only in EXECUTE.
- HALT_REQ  input  1  request halt; sampled only in COMMIT and HALTED.
- FETCH  output  1  fetch phase strobe.
- DECODE  output  1  decode phase strobe.
- EXECUTE  output  1  execute phase strobe.
- COMMIT  output  1  commit phase strobe.
- MEM_RD  output  1  memory read request; equals FETCH.
- INSTRUCTION  output  DATA_WIDTH  latched instruction word.
- PC_INC  output  1  program-counter increment, one cycle, COMMIT && PC_ENX.
- HALTED  output  1  sequencer parked at an instruction boundary.
- BUS_ERR  output  1  one-cycle pulse on fetch timeout.

Behaviour:
- Phase encoding:
  - States: IDLE, FETCH, DECODE, EXECUTE, COMMIT, HALT. All state is registered.
  - Phase outputs are decoded from state; at most one of FETCH/DECODE/EXECUTE/COMMIT/HALTED is high in any cycle.
- Reset:
  - While RESET=1 at a rising edge: state<=IDLE, INSTRUCTION<=0, wait counter<=0, BUS_ERR<=0.
  - As a result, all phase outputs, MEM_RD, PC_INC and HALTED are 0.
  - RESET overrides every other input and aborts any phase, including mid-fetch and HALT.
- IDLE -> FETCH on the first edge with RESET=0.
- FETCH:
  - MEM_RD=1.
  - On an edge with MEM_RDY=1: INSTRUCTION<=DIN, counter<=0, go to DECODE.
  - On an edge with MEM_RDY=0: counter increments and state stays FETCH.
  - Timeout: if TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1 while MEM_RDY=0, then INSTRUCTION<=NOP_OPCODE, BUS_ERR pulses high for the next cycle only, counter<=0, go to DECODE.
  - MEM_RDY=1 on the timeout edge wins: DIN is latched and there is no BUS_ERR.
- DECODE: always exactly 1 cycle, then EXECUTE.
- EXECUTE: stay while EXEC_WAIT=1; when EXEC_WAIT=0, go to COMMIT. Minimum 1 cycle.
- COMMIT:
  - Exactly 1 cycle. PC_INC = PC_ENX, combinational within COMMIT.
  - Next state is HALT if HALT_REQ=1, else FETCH.
- HALT:
  - HALTED=1; all phase strobes and MEM_RD are 0.
  - Stay while HALT_REQ=1; on HALT_REQ=0, go to FETCH.
- INSTRUCTION holds its value from the fetch-completion edge through DECODE, EXECUTE, COMMIT and HALT, until the next fetch completes.
- Minimum instruction period (MEM_RDY and no waits): 4 cycles, F D E C repeating.
- Counter width is clog2(TIMEOUT_CYCLES+1), with a minimum of 1 bit. It saturates and never wraps.

Test Plan:
- Reset and free-run:
  - Stimulus: RESET=1 for 2 cycles, then 0; MEM_RDY=1, DIN=16'h1234, PC_ENX=1.
  - Response: IDLE for 1 cycle, then F,D,E,C repeating with period 4. INSTRUCTION=16'h1234 from DECODE onward. PC_INC high only in COMMIT.
- Fetch wait:
  - Stimulus: MEM_RDY low for 3 cycles in FETCH, then high with DIN=16'hA5A5.
  - Response: FETCH/MEM_RD high for 4 cycles. DECODE follows with INSTRUCTION=16'hA5A5. BUS_ERR stays 0.
- Fetch timeout:
  - Stimulus: TIMEOUT_CYCLES=15, MEM_RDY held 0.
  - Response: after 15 FETCH cycles, DECODE with INSTRUCTION=16'h0000 and BUS_ERR=1 for exactly that DECODE cycle.
- Execute stretch and PC control:
  - Stimulus: EXEC_WAIT=1 for 2 cycles, PC_ENX=0.
  - Response: EXECUTE lasts 3 cycles, then COMMIT for 1 cycle with PC_INC=0.
- Halt:
  - Stimulus: HALT_REQ=1 during COMMIT, held 5 cycles, then 0.
  - Response: HALTED=1 for those cycles with no strobes. INSTRUCTION is unchanged. FETCH follows on the edge after HALT_REQ falls.
- Reset mid-operation:
  - Stimulus: assert RESET in EXECUTE and again in HALT.
  - Response: all outputs 0 and INSTRUCTION=0 after the edge; FETCH resumes 1 cycle after RESET deasserts.
